// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : arb_pkg
// Brief    : Shared types and constants for the unified memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

  // Arbiter FSM states: one idle state plus one busy state per requester.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2
  } arb_state_e;

  // Instruction fetches are always full 32-bit word accesses.
  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  // Default number of unacknowledged busy cycles before an access is aborted.
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 15;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : arb_watchdog
// Brief    : Clear/enable up-counter that flags the cycle in which the
//            count of enabled cycles reaches TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire in the cycle whose increment would make the count hit the limit.
  assign expire_o = en_i & ~clr_i & (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Brief    : Serialises IF-stage fetches and MEM-stage loads/stores onto one
//            single-ported memory, with fetch cancellation, stall outputs and
//            a watchdog abort on the memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_funct3_q, mem_funct3_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              drop_q, drop_d;
  logic              err_q, err_d;

  logic w_busy;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expire;
  logic w_dm_pending;
  logic w_if_pending;
  logic w_done;

  // A requester still holds its request during its own valid cycle, so a
  // request that is being answered right now must not be granted again.
  assign w_dm_pending = (dm_rd | dm_wr) & ~dm_valid_q;
  assign w_if_pending = if_req & ~if_valid_q & ~if_kill;

  assign w_busy   = (state_q != ST_IDLE);
  assign w_wd_en  = w_busy & ~mem_ready;
  assign w_wd_clr = ~w_busy | mem_ready;
  assign w_done   = w_busy & (mem_ready | w_wd_expire);

  arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (w_wd_clr),
    .en_i     (w_wd_en),
    .expire_o (w_wd_expire)
  );

  // Next-state, request and response logic; every register holds by default.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_funct3_d = mem_funct3_q;
    if_valid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    dm_valid_d   = 1'b0;
    dm_rdata_d   = dm_rdata_q;
    drop_d       = drop_q;
    err_d        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        // Data access first: it belongs to the older instruction.
        if (w_dm_pending) begin
          state_d      = ST_DM_BUSY;
          mem_req_d    = 1'b1;
          mem_we_d     = dm_wr;
          mem_addr_d   = dm_addr;
          mem_wdata_d  = dm_wdata;
          mem_funct3_d = dm_funct3;
        end else if (w_if_pending) begin
          state_d      = ST_IF_BUSY;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
          mem_funct3_d = FUNCT3_WORD;
        end
      end

      ST_IF_BUSY: begin
        if (if_kill) begin
          drop_d = 1'b1;
        end
        if (w_done) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          if (!mem_ready) begin
            err_d = 1'b1;
          end
          // A fetch cancelled at any point in its life is silently discarded.
          if (!(drop_q | if_kill)) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end
      end

      ST_DM_BUSY: begin
        if (w_done) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          dm_valid_d = 1'b1;
          dm_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
          if (!mem_ready) begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_funct3_q <= 3'b000;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
      dm_valid_q   <= 1'b0;
      dm_rdata_q   <= '0;
      drop_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_funct3_q <= mem_funct3_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
      dm_valid_q   <= dm_valid_d;
      dm_rdata_q   <= dm_rdata_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_funct3 = mem_funct3_q;
  assign if_valid   = if_valid_q;
  assign if_rdata   = if_rdata_q;
  assign dm_valid   = dm_valid_q;
  assign dm_rdata   = dm_rdata_q;
  assign err        = err_q;

  // Stalls are held low while in reset so every output reads 0 during reset.
  assign stall_if = if_req & ~if_valid_q & ~rst;
  assign stall_dm = (dm_rd | dm_wr) & ~dm_valid_q & ~rst;

endmodule
`default_nettype wire
